// File: rtl/uart_sha_pkg.sv
// uart_sha_pkg: shared constants and FSM type for the UART job loader.
// Frame bytes, status codes, payload field offsets, loader_state_t.
package uart_sha_pkg;

  localparam logic [7:0] HDR        = 8'h4A;
  localparam logic [7:0] CMD_RESET  = 8'h52;

  localparam logic [7:0] ST_ACK     = 8'h41;
  localparam logic [7:0] ST_CSUM    = 8'h43;
  localparam logic [7:0] ST_TIMEOUT = 8'h54;
  localparam logic [7:0] ST_UNEXP   = 8'h45;
  localparam logic [7:0] ST_RSTACK  = 8'h4F;

  localparam int JOB_PAYLOAD_BYTES = 84;

  localparam int OFF_DATA   = 0;
  localparam int OFF_STATE  = 12;
  localparam int OFF_TARGET = 44;
  localparam int OFF_NONCE  = 76;
  localparam int OFF_POS    = 80;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK,
    HOLD
  } loader_state_t;

endpackage

// File: rtl/uart_byte_timeout.sv
// uart_byte_timeout: idle counter, pulses expired at TIMEOUT_CYCLES-1.
// Ports: clk, rst (async high), clear, enable, expired.
module uart_byte_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // A byte on the expiry edge wins, so clear masks expired.
  assign expired = enable && !clear && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !enable || expired) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_job_loader.sv
// uart_job_loader: validates "J"+84 bytes+XOR frames into a held job.
// Ports: byte rx handshake, job valid/ready + fields, status tx handshake.
module uart_job_loader
  import uart_sha_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic              clk,
  input  logic              in_rst,
  input  logic              in_byte_valid,
  input  logic [7:0]        in_byte_data,
  output logic              out_byte_ready,
  output logic              out_job_valid,
  input  logic              in_job_ready,
  output logic [11:0][7:0]  out_job_data,
  output logic [7:0][31:0]  out_job_state,
  output logic [31:0][7:0]  out_job_target,
  output logic [31:0]       out_job_nonce_base,
  output logic [31:0]       out_job_position,
  output logic              out_status_valid,
  output logic [7:0]        out_status_code,
  input  logic              in_status_ready
);

  loader_state_t state, state_d;

  logic [JOB_PAYLOAD_BYTES-1:0][7:0] payload;
  logic [6:0] cnt;
  logic [7:0] xor_acc;
  logic [7:0] chk;

  logic accept;
  logic expired;
  logic start;
  logic load;
  logic latch;
  logic job_set;
  logic job_clr;
  logic set_status;
  logic [7:0] status_d;

  assign out_byte_ready = !in_rst && !out_status_valid &&
                          (state == IDLE || state == RECV);
  assign accept = in_byte_valid && out_byte_ready;

  uart_byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (in_rst),
    .clear  (accept || state != RECV),
    .enable (state == RECV),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge in_rst) begin
    if (in_rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    start      = 1'b0;
    load       = 1'b0;
    latch      = 1'b0;
    job_set    = 1'b0;
    job_clr    = 1'b0;
    set_status = 1'b0;
    status_d   = 8'h00;
    unique case (state)
      IDLE: begin
        if (accept) begin
          set_status = 1'b1;
          unique case (1'b1)
            (in_byte_data == HDR): begin
              set_status = 1'b0;
              start      = 1'b1;
              state_d    = RECV;
            end
            (in_byte_data == CMD_RESET): status_d = ST_RSTACK;
            default:                     status_d = ST_UNEXP;
          endcase
        end
      end
      RECV: begin
        if (accept) begin
          if (cnt == 7'(JOB_PAYLOAD_BYTES)) begin
            latch   = 1'b1;
            state_d = CHECK;
          end else begin
            load = 1'b1;
          end
        end else if (expired) begin
          set_status = 1'b1;
          status_d   = ST_TIMEOUT;
          state_d    = IDLE;
        end
      end
      CHECK: begin
        set_status = 1'b1;
        if (chk == xor_acc) begin
          job_set  = 1'b1;
          status_d = ST_ACK;
          state_d  = HOLD;
        end else begin
          status_d = ST_CSUM;
          state_d  = IDLE;
        end
      end
      HOLD: begin
        if (in_job_ready) begin
          job_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge in_rst) begin
    if (in_rst) begin
      payload          <= '0;
      cnt              <= '0;
      xor_acc          <= '0;
      chk              <= '0;
      out_job_valid    <= 1'b0;
      out_status_valid <= 1'b0;
      out_status_code  <= '0;
    end else begin
      if (start) begin
        cnt     <= '0;
        xor_acc <= '0;
      end
      if (load) begin
        cnt     <= cnt + 7'd1;
        xor_acc <= xor_acc ^ in_byte_data;
      end
      for (int i = 0; i < JOB_PAYLOAD_BYTES; i++) begin
        if (load && cnt == 7'(i)) payload[i] <= in_byte_data;
      end
      if (latch) chk <= in_byte_data;
      if (job_set) begin
        out_job_valid <= 1'b1;
      end else if (job_clr) begin
        out_job_valid <= 1'b0;
      end
      if (set_status) begin
        out_status_valid <= 1'b1;
        out_status_code  <= status_d;
      end else if (in_status_ready) begin
        out_status_valid <= 1'b0;
      end
    end
  end

  // Midstate words are big-endian, word 7 first in the stream.
  always_comb begin
    for (int i = 0; i < 12; i++) begin
      out_job_data[i] = payload[OFF_DATA + i];
    end
    for (int w = 0; w < 8; w++) begin
      out_job_state[w] = {payload[OFF_STATE + 4*(7-w)],
                          payload[OFF_STATE + 4*(7-w) + 1],
                          payload[OFF_STATE + 4*(7-w) + 2],
                          payload[OFF_STATE + 4*(7-w) + 3]};
    end
    for (int i = 0; i < 32; i++) begin
      out_job_target[i] = payload[OFF_TARGET + i];
    end
    out_job_nonce_base = {payload[OFF_NONCE], payload[OFF_NONCE+1],
                          payload[OFF_NONCE+2], payload[OFF_NONCE+3]};
    out_job_position   = {payload[OFF_POS], payload[OFF_POS+1],
                          payload[OFF_POS+2], payload[OFF_POS+3]};
  end

endmodule

// File: tb/tb_uart_job_loader.sv
// tb_uart_job_loader: directed self-checking bench for uart_job_loader.
// Covers good/bad frames, E/O codes, timeout, backpressure, async reset.
module tb_uart_job_loader;

  localparam int unsigned TO = 100;

  logic             clk = 1'b0;
  logic             in_rst = 1'b0;
  logic             in_byte_valid = 1'b0;
  logic [7:0]       in_byte_data = 8'h00;
  logic             out_byte_ready;
  logic             out_job_valid;
  logic             in_job_ready = 1'b0;
  logic [11:0][7:0] out_job_data;
  logic [7:0][31:0] out_job_state;
  logic [31:0][7:0] out_job_target;
  logic [31:0]      out_job_nonce_base;
  logic [31:0]      out_job_position;
  logic             out_status_valid;
  logic [7:0]       out_status_code;
  logic             in_status_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  uart_job_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .in_rst            (in_rst),
    .in_byte_valid     (in_byte_valid),
    .in_byte_data      (in_byte_data),
    .out_byte_ready    (out_byte_ready),
    .out_job_valid     (out_job_valid),
    .in_job_ready      (in_job_ready),
    .out_job_data      (out_job_data),
    .out_job_state     (out_job_state),
    .out_job_target    (out_job_target),
    .out_job_nonce_base(out_job_nonce_base),
    .out_job_position  (out_job_position),
    .out_status_valid  (out_status_valid),
    .out_status_code   (out_status_code),
    .in_status_ready   (in_status_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_byte_valid = 1'b1;
    in_byte_data  = b;
    @(negedge clk);
    while (!out_byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("byte_ready_wait", 64'(out_byte_ready), 64'(1));
    @(posedge clk);
    #1;
    in_byte_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] inv);
    for (int k = 0; k < 84; k++) send_byte(8'(k + 1) ^ inv);
  endtask

  task automatic send_frame(input logic [7:0] inv, input logic [7:0] ck);
    send_byte(8'h4A);
    send_payload(inv);
    send_byte(ck);
  endtask

  task automatic ack_status(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!out_status_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'({out_status_valid, out_status_code}),
          64'({1'b1, exp}));
    in_status_ready = 1'b1;
    @(posedge clk);
    #1;
    in_status_ready = 1'b0;
  endtask

  task automatic release_job(input string tag);
    in_job_ready = 1'b1;
    @(posedge clk);
    #1;
    in_job_ready = 1'b0;
    check(tag, 64'({out_job_valid, out_byte_ready}), 64'(2'b01));
  endtask

  initial begin
    int k;
    int bad_rdy;
    int bad_stab;
    logic [31:0] snap_nonce;
    logic [7:0]  snap_d0;

    #2 in_rst = 1'b1;
    #20;
    check("rst_job_valid", 64'(out_job_valid), 64'(0));
    check("rst_status", 64'({out_status_valid, out_status_code}), 64'(0));
    check("rst_ready", 64'(out_byte_ready), 64'(0));
    check("rst_nonce", 64'(out_job_nonce_base), 64'(0));
    @(negedge clk);
    in_rst = 1'b0;
    #1;
    check("rst_rel_ready", 64'(out_byte_ready), 64'(1));
    @(posedge clk);
    #1;

    // good frame
    send_frame(8'h00, 8'h54);
    check("good_in_check", 64'({out_job_valid, out_byte_ready}), 64'(0));
    @(posedge clk);
    #1;
    check("good_valid", 64'(out_job_valid), 64'(1));
    check("good_data0", 64'(out_job_data[0]), 64'(8'h01));
    check("good_data11", 64'(out_job_data[11]), 64'(8'h0C));
    check("good_state7", 64'(out_job_state[7]), 64'(32'h0D0E0F10));
    check("good_state0", 64'(out_job_state[0]), 64'(32'h292A2B2C));
    check("good_tgt0", 64'(out_job_target[0]), 64'(8'h2D));
    check("good_tgt31", 64'(out_job_target[31]), 64'(8'h4C));
    check("good_nonce", 64'(out_job_nonce_base), 64'(32'h4D4E4F50));
    check("good_pos", 64'(out_job_position), 64'(32'h51525354));
    ack_status("good_ack", 8'h41);
    check("good_hold_rdy", 64'(out_byte_ready), 64'(0));
    release_job("good_release");

    // bad checksum
    send_frame(8'h00, 8'h55);
    @(posedge clk);
    #1;
    check("bad_valid", 64'(out_job_valid), 64'(0));
    ack_status("bad_code", 8'h43);
    check("bad_idle_rdy", 64'(out_byte_ready), 64'(1));

    // unexpected byte and reset command
    send_byte(8'h41);
    check("unexp_rdy", 64'(out_byte_ready), 64'(0));
    ack_status("unexp_code", 8'h45);
    send_byte(8'h52);
    check("rcmd_rdy", 64'(out_byte_ready), 64'(0));
    ack_status("rcmd_code", 8'h4F);
    check("rcmd_after_rdy", 64'(out_byte_ready), 64'(1));

    // timeout
    send_byte(8'h4A);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
    k = 0;
    while (!out_status_valid && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("to_cycles", 64'(k), 64'(100));
    ack_status("to_code", 8'h54);
    send_frame(8'h00, 8'h54);
    @(posedge clk);
    #1;
    check("to_next_valid", 64'(out_job_valid), 64'(1));
    check("to_next_pos", 64'(out_job_position), 64'(32'h51525354));
    ack_status("to_next_ack", 8'h41);
    release_job("to_next_release");

    // backpressure with a second header offered
    send_frame(8'h00, 8'h54);
    @(posedge clk);
    #1;
    ack_status("bp_ack", 8'h41);
    in_byte_valid = 1'b1;
    in_byte_data  = 8'h4A;
    snap_nonce = out_job_nonce_base;
    snap_d0    = out_job_data[0];
    bad_rdy  = 0;
    bad_stab = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_byte_ready) bad_rdy++;
      if (!out_job_valid || out_job_nonce_base != snap_nonce ||
          out_job_data[0] != snap_d0) bad_stab++;
    end
    check("bp_ready_low", 64'(bad_rdy), 64'(0));
    check("bp_stable", 64'(bad_stab), 64'(0));
    in_job_ready = 1'b1;
    @(posedge clk);
    #1;
    in_job_ready = 1'b0;
    check("bp_release", 64'({out_job_valid, out_byte_ready}), 64'(2'b01));
    @(posedge clk);
    #1;
    in_byte_valid = 1'b0;
    send_payload(8'hFF);
    send_byte(8'h54);
    @(posedge clk);
    #1;
    check("bp2_valid", 64'(out_job_valid), 64'(1));
    check("bp2_nonce", 64'(out_job_nonce_base), 64'(32'hB2B1B0AF));
    ack_status("bp2_ack", 8'h41);
    release_job("bp2_release");

    // asynchronous reset mid-frame
    send_byte(8'h4A);
    for (int i = 0; i < 41; i++) send_byte(8'(i + 1));
    check("ar_pre_d0", 64'(out_job_data[0]), 64'(8'h01));
    #2 in_rst = 1'b1;
    #1;
    check("ar_d0", 64'(out_job_data[0]), 64'(0));
    check("ar_state7", 64'(out_job_state[7]), 64'(0));
    check("ar_ctl", 64'({out_job_valid, out_status_valid, out_byte_ready}),
          64'(0));
    @(negedge clk);
    in_rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(8'hFF, 8'h54);
    @(posedge clk);
    #1;
    check("ar_valid", 64'(out_job_valid), 64'(1));
    check("ar_d0_new", 64'(out_job_data[0]), 64'(8'hFE));
    check("ar_state7_new", 64'(out_job_state[7]), 64'(32'hF2F1F0EF));
    check("ar_pos_new", 64'(out_job_position), 64'(32'hAEADACAB));
    ack_status("ar_ack", 8'h41);
    release_job("ar_release");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
